// File: rtl/camera_burst_ctrl_pkg.sv
// camera_pkg: FSM state type and widths shared by the camera burst controller files
package camera_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_XFER, ST_DONE} state_e;
  localparam int DATA_W = 8;
  localparam int SKID_DEPTH = 2;
  localparam int SKID_CNT_W = 2;
  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction
endpackage

// File: rtl/camera_burst_ctrl_if.sv
// camera_burst_ctrl_if: FIFO read port, arbiter handshake and write-data stream of the burst controller
interface camera_burst_ctrl_if import camera_pkg::*; #(
  parameter int ADDR_W = 28,
  parameter int LVL_W = 14
);
  logic frame_start;
  logic [LVL_W-1:0] fifo_rd_level;
  logic fifo_rd_empty;
  logic fifo_rd_en;
  logic [DATA_W-1:0] fifo_rd_data;
  logic burst_req;
  logic burst_gnt;
  logic [ADDR_W-1:0] burst_addr;
  logic [DATA_W-1:0] wdata;
  logic wdata_valid;
  logic wdata_ready;
  logic burst_done;
  logic frame_done;
  logic underrun_err;
  modport master (
    input frame_start, fifo_rd_level, fifo_rd_empty, fifo_rd_data, burst_gnt, wdata_ready,
    output fifo_rd_en, burst_req, burst_addr, wdata, wdata_valid, burst_done, frame_done, underrun_err
  );
  modport slave (
    output frame_start, fifo_rd_level, fifo_rd_empty, fifo_rd_data, burst_gnt, wdata_ready,
    input fifo_rd_en, burst_req, burst_addr, wdata, wdata_valid, burst_done, frame_done, underrun_err
  );
endinterface

// File: rtl/camera_burst_ctrl_skid.sv
// camera_skid_buf: 2-entry byte FIFO with combinational head, push and pop allowed together
module camera_skid_buf import camera_pkg::*; (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_W-1:0]     din,
  output logic [DATA_W-1:0]     dout,
  output logic [SKID_CNT_W-1:0] count
);
  logic [DATA_W-1:0] mem_q [SKID_DEPTH];
  logic [DATA_W-1:0] mem_d [SKID_DEPTH];
  logic wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, pop_ok, push_ok;
  logic [SKID_CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    pop_ok = pop && cnt_q != '0;
    push_ok = push && (cnt_q != SKID_CNT_W'(SKID_DEPTH) || pop_ok);
    mem_d = mem_q;
    if (push_ok) mem_d[wr_ptr_q] = din;
    wr_ptr_d = wr_ptr_q ^ push_ok;
    rd_ptr_d = rd_ptr_q ^ pop_ok;
    cnt_d = cnt_q + SKID_CNT_W'(push_ok) - SKID_CNT_W'(pop_ok);
  end
  always_ff @(posedge clk)
    if (rst) begin
      mem_q <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q <= cnt_d;
    end
  assign dout = mem_q[rd_ptr_q];
  assign count = cnt_q;
endmodule

// File: rtl/camera_burst_ctrl.sv
// camera_burst_ctrl: drains fixed-size bursts from the camera FIFO into a write stream and tracks the frame address
module camera_burst_ctrl import camera_pkg::*; #(
  parameter int BURST_LEN = 256,
  parameter int ADDR_W = 28,
  parameter int BASE_ADDR = 0,
  parameter int FRAME_BYTES = 1843200,
  parameter int LVL_W = 14
) (
  input logic rd_clk,
  input logic rd_rst,
  camera_burst_ctrl_if.master b
);
  localparam int CW = cnt_w(BURST_LEN);
  localparam logic [CW-1:0] BL = CW'(BURST_LEN);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(BURST_LEN);
  localparam logic [ADDR_W-1:0] FRAME_END = ADDR_W'(BASE_ADDR + FRAME_BYTES);
  localparam logic [LVL_W-1:0] LVL_MIN = LVL_W'(BURST_LEN);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, next_addr;
  logic [CW-1:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic inflight_q, inflight_d, frame_pend_q, frame_pend_d, req_q, req_d;
  logic done_q, done_d, fdone_q, fdone_d, err_q, err_d;
  logic [SKID_CNT_W-1:0] skid_cnt;
  logic [DATA_W-1:0] skid_head;
  logic skid_valid, accept, reading, rd_en;
  camera_skid_buf u_skid (
    .clk   (rd_clk),
    .rst   (rd_rst),
    .push  (inflight_q),
    .pop   (accept),
    .din   (b.fifo_rd_data),
    .dout  (skid_head),
    .count (skid_cnt)
  );
  // occupancy counts this cycle's accept so a steady ready stream reads every clock
  always_comb begin
    skid_valid = skid_cnt != '0;
    accept = skid_valid && b.wdata_ready;
    reading = state_q == ST_XFER || (state_q == ST_REQ && b.burst_gnt);
    rd_en = reading && rd_cnt_q < BL && (3'(skid_cnt) + 3'(inflight_q) - 3'(accept)) < 3'd2;
    next_addr = addr_q + STEP;
    state_d = state_q;
    addr_d = addr_q;
    rd_cnt_d = rd_cnt_q + CW'(rd_en);
    wr_cnt_d = wr_cnt_q + CW'(accept);
    inflight_d = rd_en;
    frame_pend_d = frame_pend_q || b.frame_start;
    req_d = req_q;
    done_d = 1'b0;
    fdone_d = 1'b0;
    err_d = err_q || (rd_en && b.fifo_rd_empty);
    case (state_q)
      ST_IDLE: begin
        addr_d = frame_pend_d ? BASE : addr_q;
        frame_pend_d = 1'b0;
        if (b.fifo_rd_level >= LVL_MIN) begin
          state_d = ST_REQ;
          req_d = 1'b1;
          rd_cnt_d = '0;
          wr_cnt_d = '0;
        end
      end
      ST_REQ: if (b.burst_gnt) begin
        state_d = ST_XFER;
        req_d = 1'b0;
      end
      ST_XFER: if (wr_cnt_d == BL) begin
        state_d = ST_DONE;
        done_d = 1'b1;
        fdone_d = next_addr == FRAME_END;
      end
      default: begin
        addr_d = next_addr == FRAME_END ? BASE : next_addr;
        state_d = ST_IDLE;
      end
    endcase
  end
  always_ff @(posedge rd_clk)
    if (rd_rst) begin
      state_q <= ST_IDLE;
      addr_q <= BASE;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      inflight_q <= 1'b0;
      frame_pend_q <= 1'b0;
      req_q <= 1'b0;
      done_q <= 1'b0;
      fdone_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      inflight_q <= inflight_d;
      frame_pend_q <= frame_pend_d;
      req_q <= req_d;
      done_q <= done_d;
      fdone_q <= fdone_d;
      err_q <= err_d;
    end
  assign b.fifo_rd_en = rd_en;
  assign b.burst_req = req_q;
  assign b.burst_addr = addr_q;
  assign b.wdata = skid_valid ? skid_head : '0;
  assign b.wdata_valid = skid_valid;
  assign b.burst_done = done_q;
  assign b.frame_done = fdone_q;
  assign b.underrun_err = err_q;
endmodule

// File: tb/tb_camera_burst_ctrl.sv
// tb_camera_burst_ctrl: directed scenarios for the camera burst controller with a small frame
module tb_camera_burst_ctrl;
  localparam int BL = 256;
  localparam int AW = 28;
  localparam int LW = 14;
  localparam int FB = 5120;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  logic [7:0] src_byte = 8'd0;
  logic [7:0] exp_byte = 8'd0;
  int r_nrd, r_nacc, r_order, r_ovf, r_done, r_fdone, r_fd_alone, r_first, r_done_k;
  logic [AW-1:0] r_addr;
  always #5 clk = ~clk;
  camera_burst_ctrl_if #(.ADDR_W(AW), .LVL_W(LW)) b ();
  camera_burst_ctrl #(.BURST_LEN(BL), .ADDR_W(AW), .BASE_ADDR(0), .FRAME_BYTES(FB), .LVL_W(LW)) dut (
    .rd_clk (clk),
    .rd_rst (rst),
    .b      (b.master)
  );
  // FIFO without output register: byte appears the cycle after the read enable
  always @(posedge clk)
    if (b.fifo_rd_en) begin
      b.fifo_rd_data <= src_byte;
      src_byte <= src_byte + 8'd1;
    end
  task automatic run_burst(input bit rnd, input int fs_k, input int emp_k, input int rst_acc);
    int skid_m, infl_m, k;
    bit acc, fin, ab;
    r_nrd = 0; r_nacc = 0; r_order = 0; r_ovf = 0; r_done = 0; r_fdone = 0; r_fd_alone = 0;
    r_first = -1; r_done_k = -1; r_addr = '1;
    k = 0;
    do begin @(negedge clk); k++; end while (b.burst_req !== 1'b1 && k < 20);
    if (b.burst_req !== 1'b1) begin
      checks++; failures++;
      $display("FAIL req_timeout got=%b want=1", b.burst_req);
      return;
    end
    r_addr = b.burst_addr;
    b.burst_gnt = 1'b1;
    skid_m = 0; infl_m = 0; fin = 0; ab = 0;
    for (k = 0; k < 3000 && !fin && !ab; k++) begin
      if (k > 0) begin @(negedge clk); b.burst_gnt = 1'b0; end
      b.wdata_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      b.frame_start = k == fs_k;
      b.fifo_rd_empty = k == emp_k;
      #1;
      if (b.fifo_rd_en) r_nrd++;
      if (skid_m + infl_m > 2 || b.wdata_valid !== (skid_m > 0)) r_ovf++;
      acc = b.wdata_valid && b.wdata_ready;
      if (b.wdata_valid && r_first < 0) r_first = k;
      if (acc) begin
        if (b.wdata !== exp_byte) r_order++;
        exp_byte++;
        r_nacc++;
      end
      if (b.frame_done) begin r_fdone++; if (!b.burst_done) r_fd_alone++; end
      if (b.burst_done) begin r_done++; r_done_k = k; fin = 1; end
      skid_m = skid_m + infl_m - int'(acc);
      infl_m = int'(b.fifo_rd_en);
      if (rst_acc > 0 && r_nacc == rst_acc) ab = 1;
    end
    b.burst_gnt = 1'b0;
    b.frame_start = 1'b0;
    b.fifo_rd_empty = 1'b0;
    if (ab) return;
    if (!fin) begin
      checks++; failures++;
      $display("FAIL done_timeout got=%0d bytes want=%0d", r_nacc, BL);
      return;
    end
    @(negedge clk); #1;
    if (b.burst_done) r_done++;
    if (b.frame_done) r_fdone++;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    b.frame_start = 1'b0; b.fifo_rd_level = '0; b.fifo_rd_empty = 1'b0;
    b.burst_gnt = 1'b0; b.wdata_ready = 1'b1; b.fifo_rd_data = '0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if ({b.fifo_rd_en, b.burst_req, b.wdata_valid, b.burst_done, b.frame_done, b.underrun_err} !== 6'b0) begin failures++; $display("FAIL reset_flags got=%b want=000000", {b.fifo_rd_en, b.burst_req, b.wdata_valid, b.burst_done, b.frame_done, b.underrun_err}); end
    checks++; if (b.wdata !== 8'd0) begin failures++; $display("FAIL reset_wdata got=%0d want=0", b.wdata); end
    checks++; if (b.burst_addr !== '0) begin failures++; $display("FAIL reset_addr got=%0d want=0", b.burst_addr); end
    rst = 1'b0;
  endtask
  task automatic test_level_threshold;
    int bad = 0;
    b.fifo_rd_level = LW'(255);
    repeat (6) begin @(negedge clk); if (b.burst_req !== 1'b0) bad++; end
    checks++; if (bad != 0) begin failures++; $display("FAIL level255_req got=%0d high cycles want=0", bad); end
    b.fifo_rd_level = LW'(256);
    repeat (2) @(negedge clk);
    #1;
    checks++; if (b.burst_req !== 1'b1) begin failures++; $display("FAIL level256_req got=%b want=1", b.burst_req); end
    checks++; if (b.burst_addr !== '0) begin failures++; $display("FAIL level256_addr got=%0d want=0", b.burst_addr); end
  endtask
  task automatic test_full_burst;
    run_burst(1'b0, -1, -1, 0);
    checks++; if (r_addr !== AW'(0)) begin failures++; $display("FAIL full_addr got=%0d want=0", r_addr); end
    checks++; if (r_nrd != BL) begin failures++; $display("FAIL full_reads got=%0d want=%0d", r_nrd, BL); end
    checks++; if (r_nacc != BL) begin failures++; $display("FAIL full_accepts got=%0d want=%0d", r_nacc, BL); end
    checks++; if (r_order != 0) begin failures++; $display("FAIL full_order got=%0d bad want=0", r_order); end
    checks++; if (r_done != 1) begin failures++; $display("FAIL full_done_pulses got=%0d want=1", r_done); end
    checks++; if (r_first != 2) begin failures++; $display("FAIL full_first_valid got=%0d want=2", r_first); end
    checks++; if (r_done_k != BL + 2) begin failures++; $display("FAIL full_done_cycle got=%0d want=%0d", r_done_k, BL + 2); end
    checks++; if (r_ovf != 0) begin failures++; $display("FAIL full_occupancy got=%0d bad want=0", r_ovf); end
    checks++; if (r_fdone != 0) begin failures++; $display("FAIL full_frame_done got=%0d want=0", r_fdone); end
  endtask
  task automatic test_random_ready;
    run_burst(1'b1, -1, -1, 0);
    checks++; if (r_addr !== AW'(256)) begin failures++; $display("FAIL rnd_addr got=%0d want=256", r_addr); end
    checks++; if (r_nrd != BL) begin failures++; $display("FAIL rnd_reads got=%0d want=%0d", r_nrd, BL); end
    checks++; if (r_nacc != BL) begin failures++; $display("FAIL rnd_accepts got=%0d want=%0d", r_nacc, BL); end
    checks++; if (r_order != 0) begin failures++; $display("FAIL rnd_order got=%0d bad want=0", r_order); end
    checks++; if (r_ovf != 0) begin failures++; $display("FAIL rnd_occupancy got=%0d bad want=0", r_ovf); end
    checks++; if (r_done != 1) begin failures++; $display("FAIL rnd_done_pulses got=%0d want=1", r_done); end
  endtask
  task automatic test_frame_wrap;
    int addr_err = 0, fd_err = 0, data_err = 0, k = 0;
    for (int a = 512; a < FB; a += BL) begin
      run_burst(1'b0, -1, -1, 0);
      if (r_addr !== AW'(a)) addr_err++;
      if (r_nacc != BL || r_order != 0 || r_done != 1) data_err++;
      if (r_fdone != ((a == FB - BL) ? 1 : 0) || r_fd_alone != 0) fd_err++;
    end
    checks++; if (addr_err != 0) begin failures++; $display("FAIL wrap_addr_seq got=%0d bad want=0", addr_err); end
    checks++; if (data_err != 0) begin failures++; $display("FAIL wrap_data got=%0d bad want=0", data_err); end
    checks++; if (fd_err != 0) begin failures++; $display("FAIL wrap_frame_done got=%0d bad want=0", fd_err); end
    do begin @(negedge clk); k++; end while (b.burst_req !== 1'b1 && k < 20);
    checks++; if (b.burst_req !== 1'b1 || b.burst_addr !== '0) begin failures++; $display("FAIL wrap_next_addr got=%0d req=%b want=0 req=1", b.burst_addr, b.burst_req); end
  endtask
  task automatic test_frame_start;
    int addr_err = 0, k = 0;
    for (int a = 0; a < 4096; a += BL) begin
      run_burst(1'b0, -1, -1, 0);
      if (r_addr !== AW'(a) || r_nacc != BL) addr_err++;
    end
    checks++; if (addr_err != 0) begin failures++; $display("FAIL fs_addr_seq got=%0d bad want=0", addr_err); end
    run_burst(1'b0, 50, -1, 0);
    checks++; if (r_addr !== AW'(4096)) begin failures++; $display("FAIL fs_burst_addr got=%0d want=4096", r_addr); end
    checks++; if (r_nacc != BL || r_done != 1) begin failures++; $display("FAIL fs_burst_complete got=%0d bytes %0d done want=%0d bytes 1 done", r_nacc, r_done, BL); end
    checks++; if (r_fdone != 0) begin failures++; $display("FAIL fs_frame_done got=%0d want=0", r_fdone); end
    do begin @(negedge clk); k++; end while (b.burst_req !== 1'b1 && k < 20);
    checks++; if (b.burst_req !== 1'b1 || b.burst_addr !== '0) begin failures++; $display("FAIL fs_next_addr got=%0d req=%b want=0 req=1", b.burst_addr, b.burst_req); end
  endtask
  task automatic test_reset_abort;
    run_burst(1'b0, -1, -1, 100);
    checks++; if (r_nacc != 100 || r_done != 0) begin failures++; $display("FAIL abort_partial got=%0d bytes %0d done want=100 bytes 0 done", r_nacc, r_done); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++; if ({b.fifo_rd_en, b.burst_req, b.wdata_valid, b.burst_done, b.frame_done, b.underrun_err} !== 6'b0 || b.wdata !== 8'd0) begin failures++; $display("FAIL abort_outputs got=%b/%0d want=000000/0", {b.fifo_rd_en, b.burst_req, b.wdata_valid, b.burst_done, b.frame_done, b.underrun_err}, b.wdata); end
    checks++; if (b.burst_addr !== '0) begin failures++; $display("FAIL abort_addr got=%0d want=0", b.burst_addr); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    exp_byte = src_byte;
    run_burst(1'b0, -1, -1, 0);
    checks++; if (r_addr !== AW'(0)) begin failures++; $display("FAIL restart_addr got=%0d want=0", r_addr); end
    checks++; if (r_nacc != BL || r_nrd != BL || r_order != 0 || r_done != 1) begin failures++; $display("FAIL restart_burst got=%0d acc %0d rd %0d order want=%0d acc %0d rd 0 order", r_nacc, r_nrd, r_order, BL, BL); end
  endtask
  task automatic test_underrun;
    checks++; if (b.underrun_err !== 1'b0) begin failures++; $display("FAIL underrun_before got=%b want=0", b.underrun_err); end
    run_burst(1'b0, -1, 10, 0);
    checks++; if (b.underrun_err !== 1'b1) begin failures++; $display("FAIL underrun_set got=%b want=1", b.underrun_err); end
    checks++; if (r_addr !== AW'(256) || r_nrd != BL || r_nacc != BL || r_order != 0) begin failures++; $display("FAIL underrun_burst got=addr %0d rd %0d acc %0d want=addr 256 rd %0d acc %0d", r_addr, r_nrd, r_nacc, BL, BL); end
    repeat (5) @(negedge clk);
    checks++; if (b.underrun_err !== 1'b1) begin failures++; $display("FAIL underrun_sticky got=%b want=1", b.underrun_err); end
  endtask
  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end
  initial begin
    void'($urandom(32'd7));
    test_reset();
    test_level_threshold();
    test_full_burst();
    test_random_ready();
    test_frame_wrap();
    test_frame_start();
    test_reset_abort();
    test_underrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
